level_meter: RTL and testbench

LEVEL_METER -- requirements
Module: level_meter

---
 rtl/level_meter.sv | 89 ++++++++
 tb/tb_level_meter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/level_meter.sv
// level_meter: windowed peak-magnitude meter with hold and decay of a 0..15 bar level
module level_meter #(
  parameter int WINDOW = 1024,
  parameter int HOLD   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic [3:0] level,
  output logic       level_valid
);
  localparam int CW = $clog2(WINDOW);
  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_DECAY} state_t;
  state_t state, nstate;
  logic [CW-1:0] cnt;
  logic [6:0] mag, peak, pk;
  logic [3:0] win_lvl, lvl_q, nlevel;
  logic [7:0] hold_cnt, nhold;
  logic pend, vld_q, close, raise;
  assign mag = din[7] ? din[6:0] : (din == 8'd0 ? 7'd127 : 7'(8'd128 - din));
  assign pk = mag > peak ? mag : peak;
  assign close = din_valid && cnt == CW'(WINDOW - 1);
  assign raise = win_lvl >= lvl_q;
  // window counter and peak; the closing peak is latched and applied on the next edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      peak <= '0;
      win_lvl <= '0;
      pend <= 1'b0;
    end else begin
      pend <= close;
      if (din_valid) begin
        cnt <= close ? '0 : cnt + CW'(1);
        peak <= close ? '0 : pk;
      end
      if (close) win_lvl <= pk[6:3];
    end
  end
  // state, level and hold counter update once per closed window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      lvl_q <= '0;
      hold_cnt <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= pend;
      if (pend) begin
        state <= nstate;
        lvl_q <= nlevel;
        hold_cnt <= nhold;
      end
    end
  end
  // hold/decay transition rules evaluated on the latched window level
  always_comb begin
    nstate = state;
    nlevel = lvl_q;
    nhold = hold_cnt;
    case (state)
      S_IDLE: if (win_lvl != 4'd0) begin
        nlevel = win_lvl;
        nhold = 8'(HOLD);
        nstate = S_HOLD;
      end
      S_HOLD: if (raise) begin
        nlevel = win_lvl;
        nhold = 8'(HOLD);
      end else if (hold_cnt == 8'd1) nstate = S_DECAY;
      else nhold = hold_cnt - 8'd1;
      S_DECAY: if (raise) begin
        nlevel = win_lvl;
        nhold = 8'(HOLD);
        nstate = S_HOLD;
      end else begin
        nlevel = lvl_q - 4'd1;
        nstate = lvl_q == 4'd1 ? S_IDLE : S_DECAY;
      end
      default: nstate = S_IDLE;
    endcase
  end
  // registered level and update strobe drive the outputs
  always_comb begin
    level = lvl_q;
    level_valid = vld_q;
  end
endmodule

// File: tb/tb_level_meter.sv
// tb_level_meter: directed and randomized checks of level_meter against a window-level reference model
module tb_level_meter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] din = 8'd128;
  logic din_valid = 1'b0;
  logic [3:0] level;
  logic level_valid;
  int total = 0;
  int bad = 0;
  int mstate, mlevel, mhold, mwl, exp_valid;
  bit mpend;
  int q[$];

  level_meter #(.WINDOW(4), .HOLD(2)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .level(level), .level_valid(level_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  function automatic int magf(input int d);
    return d >= 128 ? d - 128 : (128 - d > 127 ? 127 : 128 - d);
  endfunction

  task automatic mreset();
    mstate = 0; mlevel = 0; mhold = 0; mpend = 0; exp_valid = 0;
    q.delete();
  endtask

  task automatic apply(input int w);
    if (mstate == 0) begin
      if (w > 0) begin mlevel = w; mhold = 2; mstate = 1; end
    end else if (mstate == 1) begin
      if (w >= mlevel) begin mlevel = w; mhold = 2; end
      else if (mhold == 1) mstate = 2;
      else mhold--;
    end else begin
      if (w >= mlevel) begin mlevel = w; mhold = 2; mstate = 1; end
      else begin mlevel--; if (mlevel == 0) mstate = 0; end
    end
  endtask

  task automatic step(input bit v, input int d);
    int mx;
    din = 8'(d);
    din_valid = v;
    @(posedge clk);
    exp_valid = mpend;
    if (mpend) apply(mwl);
    mpend = 0;
    if (v) begin
      q.push_back(magf(d));
      if (q.size() == 4) begin
        mx = 0;
        foreach (q[i]) if (q[i] > mx) mx = q[i];
        mwl = mx / 8;
        mpend = 1;
        q.delete();
      end
    end
    #1;
    chk("level", level, mlevel);
    chk("level_valid", level_valid, exp_valid);
  endtask

  task automatic win(input int a, input int b, input int c, input int d);
    step(1, a); step(1, b); step(1, c); step(1, d);
    step(0, 128);
  endtask

  task automatic win4(input int d);
    win(d, d, d, d);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_level", level, 0);
    chk("rst_valid", level_valid, 0);
    mreset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    mreset();
    repeat (2) @(posedge clk);
    #1;
    chk("por_level", level, 0);
    chk("por_valid", level_valid, 0);
    rst = 1'b0;
    win4(128);
    chk("quiet", level, 0);
    win(128, 200, 128, 128);
    chk("bar9", level, 9);
    repeat (11) win4(128);
    chk("decay_to_0", level, 0);
    win4(200);
    chk("bar9_again", level, 9);
    repeat (6) win4(128);
    chk("decayed_5", level, 5);
    win4(160);
    chk("no_raise_4", level, 4);
    win4(200);
    chk("raise_9", level, 9);
    win(128, 0, 128, 128);
    chk("sat_0", level, 15);
    win(128, 128, 255, 128);
    chk("sat_255", level, 15);
    step(1, 200); step(1, 200);
    do_reset();
    step(1, 255); step(1, 255); step(1, 255);
    chk("no_early_pulse", level_valid, 0);
    step(1, 136); step(0, 128);
    chk("post_rst_win", level, 15);
    do_reset();
    win4(136);
    chk("lvl1", level, 1);
    do_reset();
    win4(135);
    chk("lvl0", level, 0);
    step(1, 180); step(1, 180);
    repeat (10) step(0, 128);
    step(1, 180); step(1, 180);
    step(0, 128);
    chk("gap_pulse", level_valid, 1);
    step(0, 128);
    repeat (16) step(1, 150);
    for (int n = 0; n < 400; n++) begin
      int r, off, d;
      r = $urandom_range(0, 9);
      off = $urandom_range(0, r < 6 ? 12 : 130);
      d = $urandom_range(0, 1) ? 128 + off : 128 - off;
      d = d < 0 ? 0 : (d > 255 ? 255 : d);
      if (n == 200) do_reset();
      step($urandom_range(0, 3) != 0, d);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
